rng_share_ctrl: RTL and testbench
=================================

Name: rng_share_ctrl

Overview:
- Owns a 32-bit maximal-length LFSR and shares it among NUM_REQ requesters.
- Round-robin arbitration; each requester gets a fresh non-zero 32-bit random value through a same-cycle req/gnt handshake.
- Sequences the LFSR: seeding, post-seed warm-up and stepping.
- Sits between the game-logic consumers (spawners, movement, scoring) and the random source.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEED, 32'hACE1_2468, reset seed and substitute for a zero seed; must be non-zero.
- WARMUP, 16, LFSR steps discarded after reset or seed load (0..255; 0 means no warm-up).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  load seed_data into the LFSR on the next edge.
- seed_data  in  32  new seed value.
- req  in  NUM_REQ  per-requester request, level.
- gnt  out  NUM_REQ  one-hot grant, same cycle as req; zero or one bit set.
- rand_out  out  32  current LFSR state; valid for the granted requester when |gnt.
- busy  out  1  high during WARMUP; no grants while high.

Behaviour:
- Reset (async, rst_n=0):
  - lfsr=SEED; rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - warm counter=WARMUP; state=WARMUP, or READY if WARMUP==0.
  - gnt=0; busy=1, or 0 if WARMUP==0; rand_out=SEED.
- LFSR step, Fibonacci shift-left: next = {s[30:0], s[31]^s[21]^s[1]^s[0]} (taps 32,22,2,1). Never reaches zero from a non-zero state.
- Seed load: seed_data==0 loads SEED instead. The loaded value never equals zero.
- State WARMUP:
  - busy=1, gnt=0; LFSR steps every cycle; counter decrements.
  - Counter reaching 1 → READY on the next edge. After exactly WARMUP steps, state=READY.
- State READY:
  - busy=0.
  - gnt is combinational: the first asserted req bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - rand_out=lfsr (registered). Zero latency: the grant and value belong to the same cycle.
  - On an edge with |gnt: LFSR steps once; rr_ptr = index of the granted bit.
  - No grant: LFSR holds; see Optional Feature.
- Handshake: a requester holding req high receives one value per cycle it is granted. To take exactly one value it drops req in the cycle after gnt.
- Fairness: with all req high, grants rotate 0,1,..,NUM_REQ-1,0,... A lone requester is granted every cycle.
- seed_load:
  - Accepted in any state; highest priority over req.
  - gnt forced 0 in the seed_load cycle; LFSR does not step on grants that cycle.
  - Next edge: lfsr=seed, warm counter=WARMUP, state=WARMUP, or READY if WARMUP==0. rr_ptr is unchanged.
- seed_load during WARMUP restarts the warm-up from the new seed.
- Reset mid-grant: gnt drops asynchronously; no value is considered delivered.
- Consecutive values handed out are distinct: the LFSR period is 2^32-1.

Optional Feature:
- Macro RNG_FREERUN_EN.
- Defined: in READY the LFSR also steps on cycles with no grant (free-running entropy from request timing). Granted values remain distinct.
- Undefined: the LFSR steps only on grants and during warm-up. The sequence is then fully deterministic per seed, which the test plan relies on.

Decomposition:
- Package rng_pkg holds:
  - LFSR_W=32 and the tap mask constant.
  - DEFAULT_SEED.
  - State enum {WARMUP, READY}.
  - Function lfsr_next(s).
- One sub-module, rng_rr_pick: combinational round-robin picker taking req and rr_ptr and returning one-hot gnt and the encoded index. It is reusable for other shared resources.
- The LFSR register and warm-up counter stay in the top.

Test Plan (RNG_FREERUN_EN undefined unless stated):
- WARMUP=0, seed_load seed_data=32'h1, then req=4'b0001 held 5 cycles → gnt[0] each cycle, rand_out = 0x1, 0x3, 0x6, 0xD, 0x1B.
- seed_data=0 with WARMUP=0 → first granted rand_out = 32'hACE1_2468, never 0.
- WARMUP=16 after reset → busy=1 and gnt=0 for 16 cycles with req=4'b1111; cycle 17 gives busy=0, gnt=4'b0001.
- req=4'b1111 held 8 cycles in READY → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; 8 distinct rand_out values.
- req=4'b1010 with seed_load pulsed in the same cycle → gnt=0 that cycle; next cycle busy=1 (WARMUP=16); after warm-up, grants resume.
- Async reset: rst_n low mid-grant → gnt=0 immediately, lfsr=SEED; with RNG_FREERUN_EN defined and WARMUP=0, 10 idle cycles then req=4'b0001 → rand_out equals lfsr_next applied 10 times to SEED.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and LFSR helpers for the random-number sharing controller.
// Feature macro RNG_FREERUN_EN is consumed by rng_share_ctrl, not here.
package rng_pkg;

   localparam int                 LFSR_W       = 32;
   // Taps 32,22,2,1 expressed as bit positions 31,21,1,0.
   localparam logic [LFSR_W-1:0]  TAP_MASK     = 32'h8020_0003;
   localparam logic [LFSR_W-1:0]  DEFAULT_SEED = 32'hACE1_2468;

   typedef enum logic {
      ST_WARMUP = 1'b0,
      ST_READY  = 1'b1
   } rng_state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
   endfunction

endpackage

// File: rtl/rng_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after ptr,
// wrapping modulo N. Returns one-hot grant, encoded index and a found flag.
module rng_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   int cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 1; off <= N; off++) begin
         cand = (int'(ptr) + off) % N;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rng_share_ctrl.sv
// Shares one 32-bit maximal-length LFSR among NUM_REQ round-robin requesters.
// Define RNG_FREERUN_EN to let the LFSR step on idle READY cycles as well.
module rng_share_ctrl #(
   parameter int          NUM_REQ = 4,
   parameter logic [31:0] SEED    = rng_pkg::DEFAULT_SEED,
   parameter int          WARMUP  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       seed_load,
   input  logic [rng_pkg::LFSR_W-1:0] seed_data,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [rng_pkg::LFSR_W-1:0] rand_out,
   output logic                       busy
);

   import rng_pkg::*;

   localparam int         IDX_W     = $clog2(NUM_REQ);
   localparam logic [7:0] WARM_INIT = 8'(WARMUP);
   localparam rng_state_e START_ST  = (WARMUP == 0) ? ST_READY : ST_WARMUP;
   localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

   rng_state_e          state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [7:0]          warm_q, warm_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_found;
   logic                grant_ok;

   rng_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // rst_n gates the grant so it falls the instant reset asserts.
   assign grant_ok = rst_n && (state_q == ST_READY) && !seed_load;

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      warm_d   = warm_q;
      rr_ptr_d = rr_ptr_q;
      gnt      = grant_ok ? pick_gnt : '0;

      if (seed_load) begin
         lfsr_d  = (seed_data == '0) ? SEED : seed_data;
         warm_d  = WARM_INIT;
         state_d = START_ST;
      end else if (state_q == ST_WARMUP) begin
         lfsr_d = lfsr_next(lfsr_q);
         warm_d = warm_q - 8'd1;
         if (warm_q == 8'd1) begin
            state_d = ST_READY;
         end
      end else if (pick_found) begin
         lfsr_d   = lfsr_next(lfsr_q);
         rr_ptr_d = pick_idx;
      end
`ifdef RNG_FREERUN_EN
      else begin
         lfsr_d = lfsr_next(lfsr_q);
      end
`else
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= START_ST;
         lfsr_q   <= SEED;
         warm_q   <= WARM_INIT;
         rr_ptr_q <= PTR_INIT;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         warm_q   <= warm_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign rand_out = lfsr_q;
   assign busy     = (state_q == ST_WARMUP);

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Bench for rng_share_ctrl: two instances (WARMUP=0 and WARMUP=16) on shared
// stimulus, a behavioural model checked every cycle, plus literal expectations.
module tb_rng_share_ctrl;

   localparam logic [31:0] SEED = 32'hACE1_2468;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seed_load = 1'b0;
   logic [31:0] seed_data = '0;
   logic [3:0]  req = '0;

   logic [3:0]  gnt_w [2];
   logic [31:0] rnd_w [2];
   logic        busy_w [2];

   always #5 clk = ~clk;

   rng_share_ctrl #(.NUM_REQ(4), .SEED(SEED), .WARMUP(0)) u_dut_w0 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
      .req(req), .gnt(gnt_w[0]), .rand_out(rnd_w[0]), .busy(busy_w[0])
   );

   rng_share_ctrl #(.NUM_REQ(4), .SEED(SEED), .WARMUP(16)) u_dut_w16 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
      .req(req), .gnt(gnt_w[1]), .rand_out(rnd_w[1]), .busy(busy_w[1])
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic int wu(input int k);
      return (k == 0) ? 0 : 16;
   endfunction

   // Next requester after ptr in cyclic order, -1 if none asks.
   function automatic int pick(input logic [3:0] r, input int ptr);
      for (int k = 1; k <= 4; k++) begin
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   logic [31:0] m_lfsr [2];
   int          m_rem  [2];
   int          m_ptr  [2];
   int          m_g;

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_lfsr[k] = SEED;
            m_rem[k]  = wu(k);
            m_ptr[k]  = 3;
         end else if (seed_load) begin
            m_lfsr[k] = (seed_data == 0) ? SEED : seed_data;
            m_rem[k]  = wu(k);
         end else if (m_rem[k] > 0) begin
            m_lfsr[k] = step(m_lfsr[k]);
            m_rem[k]  = m_rem[k] - 1;
         end else begin
            m_g = pick(req, m_ptr[k]);
            if (m_g >= 0) begin
               m_lfsr[k] = step(m_lfsr[k]);
               m_ptr[k]  = m_g;
            end
`ifdef RNG_FREERUN_EN
            else m_lfsr[k] = step(m_lfsr[k]);
`endif
         end
      end
   end

   logic [3:0] exp_g;
   int         eg;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         exp_g = '0;
         if (rst_n && !seed_load && m_rem[k] == 0) begin
            eg = pick(req, m_ptr[k]);
            if (eg >= 0) exp_g[eg] = 1'b1;
         end
         check($sformatf("model_gnt_w%0d", wu(k)), {28'd0, gnt_w[k]}, {28'd0, exp_g});
         check($sformatf("model_busy_w%0d", wu(k)), {31'd0, busy_w[k]}, {31'd0, (m_rem[k] > 0)});
         check($sformatf("model_rand_w%0d", wu(k)), rnd_w[k], m_lfsr[k]);
      end
   end

   logic [31:0] vals [8];
   logic [31:0] lit_seq [5];
   logic [31:0] exp10;
   int          dups;

   initial begin
      lit_seq[0] = 32'h1;  lit_seq[1] = 32'h3;  lit_seq[2] = 32'h6;
      lit_seq[3] = 32'hD;  lit_seq[4] = 32'h1B;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; req = 4'b1111;

      // Warm-up on the WARMUP=16 instance; the WARMUP=0 instance grants at once.
      @(negedge clk);
      check("rst_rand_w16", rnd_w[1], SEED);
      check("rst_rand_w0", rnd_w[0], SEED);
      check("rst_busy_w0", {31'd0, busy_w[0]}, 32'd0);
      check("first_gnt_w0", {28'd0, gnt_w[0]}, 32'h1);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         check("warm_busy_w16", {31'd0, busy_w[1]}, 32'd1);
         check("warm_gnt_w16", {28'd0, gnt_w[1]}, 32'd0);
      end

      // Rotation with all requesters asserted.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) check("ready_busy_w16", {31'd0, busy_w[1]}, 32'd0);
         check("rot_gnt_w16", {28'd0, gnt_w[1]}, 32'd1 << (i % 4));
         vals[i] = rnd_w[1];
      end
      dups = 0;
      for (int i = 0; i < 8; i++)
         for (int j = i + 1; j < 8; j++)
            if (vals[i] == vals[j]) dups++;
      check("rot_distinct_w16", dups, 0);

      // seed_load collides with requests.
      @(posedge clk); #1 req = 4'b1010; seed_load = 1'b1; seed_data = 32'h1;
      @(negedge clk);
      check("sload_gnt_w16", {28'd0, gnt_w[1]}, 32'd0);
      check("sload_gnt_w0", {28'd0, gnt_w[0]}, 32'd0);
      @(posedge clk); #1 seed_load = 1'b0; req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) check("sload_busy_w16", {31'd0, busy_w[1]}, 32'd1);
         check("seed1_gnt_w0", {28'd0, gnt_w[0]}, 32'h1);
         check("seed1_rand_w0", rnd_w[0], lit_seq[i]);
      end
      @(posedge clk); #1 req = 4'b1010;
      repeat (11) @(posedge clk);
      @(negedge clk);
      check("resume_busy_w16", {31'd0, busy_w[1]}, 32'd0);
      check("resume_gnt_w16", {28'd0, gnt_w[1]}, 32'h2);

      // Zero seed substitutes SEED.
      @(posedge clk); #1 seed_load = 1'b1; seed_data = 32'h0; req = 4'b0000;
      @(posedge clk); #1 seed_load = 1'b0; req = 4'b0001;
      @(negedge clk);
      check("zseed_gnt_w0", {28'd0, gnt_w[0]}, 32'h1);
      check("zseed_rand_w0", rnd_w[0], SEED);

      // Asynchronous reset in the middle of a grant.
      @(posedge clk); #1;
      check("pre_rst_gnt_w0", {28'd0, gnt_w[0]}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("async_gnt_w0", {28'd0, gnt_w[0]}, 32'd0);
      check("async_rand_w0", rnd_w[0], SEED);
      req = 4'b0000;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 req = 4'b0001;
      exp10 = SEED;
`ifdef RNG_FREERUN_EN
      for (int i = 0; i < 10; i++) exp10 = step(exp10);
`endif
      @(negedge clk);
      check("idle10_gnt_w0", {28'd0, gnt_w[0]}, 32'h1);
      check("idle10_rand_w0", rnd_w[0], exp10);

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
